// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer.
//   seq_state_e : sequencer FSM states
//   RELOCK_W    : width of the saturating relock counter
//   cnt_w()     : counter width for a given cycle limit (at least 1 bit)
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_e;

  localparam int unsigned RELOCK_W = 32'd8;

  // A counter that runs 0 .. limit-1 needs $clog2(limit) bits; never return 0 bits.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit < 32'd2) ? 32'd1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing the asynchronous PLL LOCK into clk.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state for the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings the rPLL up from power-on and gates the system reset.
//   Pulses pll_reset, waits for LOCK, requires it to stay high for a qualification
//   window, then releases sys_reset. A filtered loss of lock in RUN restarts the
//   sequence and bumps a saturating relock counter.
// Ports:
//   clk          : free-running board clock (same net as the PLL input clock)
//   reset        : asynchronous active-high reset
//   pll_lock     : rPLL LOCK, asynchronous to clk
//   pll_reset    : rPLL RESET, active-high
//   sys_reset    : system reset, active-high
//   locked       : high only in RUN
//   relock_count : saturating count of lock losses seen in RUN
//   fault        : retry limit exhausted
// Build option: define PLL_RETRY_LIMIT_EN to enable the retry limit and the terminal
//   FAULT state; without it the sequencer retries forever and fault is tied low.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = 32'd16,
  parameter int unsigned LOCK_TIMEOUT       = 32'd27000,
  parameter int unsigned LOCK_STABLE_CYCLES = 32'd2700,
  parameter int unsigned LOSS_FILTER        = 32'd4,
  parameter int unsigned MAX_RETRIES        = 32'd7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic                sys_reset,
  output logic                locked,
  output logic [RELOCK_W-1:0] relock_count,
  output logic                fault
);

  // One cycle counter is shared by PLL_RST, WAIT_LOCK and STABLE, so it is sized
  // for the largest of the three limits.
  localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W     = cnt_w(CNT_MAX);
  localparam int unsigned FLT_W     = cnt_w(LOSS_FILTER);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER - 32'd1);

  logic                lock_s;
  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FLT_W-1:0]    flt_q, flt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_reset_q, pll_reset_d;
  logic                sys_reset_q, sys_reset_d;
  logic                locked_q, locked_d;
`ifdef PLL_RETRY_LIMIT_EN
  localparam int unsigned RETRY_W = cnt_w(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 32'd1);
  logic [RETRY_W-1:0]  retries_q, retries_d;
  logic                fault_q, fault_d;
`endif

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state, counter and output decode for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flt_d    = {FLT_W{1'b0}};
    relock_d = relock_q;
`ifdef PLL_RETRY_LIMIT_EN
    retries_d = retries_q;
`endif
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle wins over the retry.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = {CNT_W{1'b0}};
`ifdef PLL_RETRY_LIMIT_EN
          if (retries_q == RETRY_LAST) begin
            state_d = FAULT;
          end else begin
            state_d   = PLL_RST;
            retries_d = retries_q + RETRY_W'(1'b1);
          end
`else
          state_d = PLL_RST;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
`ifdef PLL_RETRY_LIMIT_EN
          retries_d = {RETRY_W{1'b0}};
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      RUN: begin
        // Only a run of LOSS_FILTER consecutive low cycles counts as a loss.
        if (lock_s) begin
          flt_d = {FLT_W{1'b0}};
        end else if (flt_q == FLT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = {CNT_W{1'b0}};
          flt_d   = {FLT_W{1'b0}};
          if (relock_q != {RELOCK_W{1'b1}}) begin
            relock_d = relock_q + RELOCK_W'(1'b1);
          end else begin
            relock_d = relock_q;
          end
        end else begin
          flt_d = flt_q + FLT_W'(1'b1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Outputs follow the next state so they change on the same edge as the state.
    pll_reset_d = (state_d == PLL_RST) || (state_d == FAULT);
    sys_reset_d = (state_d != RUN);
    locked_d    = (state_d == RUN);
`ifdef PLL_RETRY_LIMIT_EN
    fault_d     = (state_d == FAULT);
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= {CNT_W{1'b0}};
      flt_q       <= {FLT_W{1'b0}};
      relock_q    <= {RELOCK_W{1'b0}};
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
      retries_q   <= {RETRY_W{1'b0}};
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flt_q       <= flt_d;
      relock_q    <= relock_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      locked_q    <= locked_d;
`ifdef PLL_RETRY_LIMIT_EN
      retries_q   <= retries_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign pll_reset    = pll_reset_q;
  assign sys_reset    = sys_reset_q;
  assign locked       = locked_q;
  assign relock_count = relock_q;
`ifdef PLL_RETRY_LIMIT_EN
  assign fault        = fault_q;
`else
  assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TMO_C = 32;
  localparam int STB_C = 8;
  localparam int FLT_C = 3;
  localparam int RETRY_C = 2;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic [7:0] relock_count;
  logic       fault;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES     (RST_C),
    .LOCK_TIMEOUT       (TMO_C),
    .LOCK_STABLE_CYCLES (STB_C),
    .LOSS_FILTER        (FLT_C),
    .MAX_RETRIES        (RETRY_C)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .sys_reset    (sys_reset),
    .locked       (locked),
    .relock_count (relock_count),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0d with no expected value queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic chk_reset_vals(input string where);
    push({where, "_pll_reset"}, 32'd1);
    push({where, "_sys_reset"}, 32'd1);
    push({where, "_locked"},    32'd0);
    push({where, "_relock"},    32'd0);
    push({where, "_fault"},     32'd0);
    chk({31'd0, pll_reset});
    chk({31'd0, sys_reset});
    chk({31'd0, locked});
    chk({24'd0, relock_count});
    chk({31'd0, fault});
  endtask

  initial begin
    int k, lat, r1, r2, viol, model, tmo_seen;
    logic prev;
    bit sat_checked;

    // ---- reset state ----
    reset = 1'b1;
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_init");

    // ---- test 1: power-up sequence, lock 10 cycles after release ----
    reset = 1'b0;
    push("pll_reset_pulse_len", RST_C);
    k = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pll_reset == 1'b0 && lat < 0) begin
        lat = i;
        break;
      end
    end
    chk(lat);
    repeat (10 - RST_C) @(negedge clk);
    pll_lock = 1'b1;
    push("lock_to_release", STB_C + 3);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sys_reset == 1'b0) begin
        lat = i;
        break;
      end
    end
    chk(lat);
    push("t1_locked", 32'd1);
    push("t1_pll_reset", 32'd0);
    chk({31'd0, locked});
    chk({31'd0, pll_reset});

    // ---- test 4: short glitch ignored, filter-length loss detected ----
    pll_lock = 1'b0;
    repeat (FLT_C - 1) @(negedge clk);
    pll_lock = 1'b1;
    repeat (8) @(negedge clk);
    push("glitch2_sys_reset", 32'd0);
    push("glitch2_locked", 32'd1);
    push("glitch2_relock", 32'd0);
    chk({31'd0, sys_reset});
    chk({31'd0, locked});
    chk({24'd0, relock_count});

    pll_lock = 1'b0;
    push("loss_latency", FLT_C + 2);
    push("loss_pll_reset", 32'd1);
    push("loss_locked", 32'd0);
    push("loss_relock", 32'd1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == FLT_C) pll_lock = 1'b1;
      if (sys_reset == 1'b1) begin
        lat = i;
        break;
      end
    end
    chk(lat);
    chk({31'd0, pll_reset});
    chk({31'd0, locked});
    chk({24'd0, relock_count});
    // lock already high: PLL_RST, one WAIT_LOCK cycle, then the stable window
    push("relock_latency", RST_C + 1 + STB_C);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sys_reset == 1'b0) begin
        lat = i;
        break;
      end
    end
    chk(lat);

    // ---- test 3: glitch during STABLE restarts qualification ----
    pll_lock = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sys_reset == 1'b1) break;
    end
    push("t3_relock", 32'd2);
    chk({24'd0, relock_count});
    repeat (10) @(negedge clk);
    pll_lock = 1'b1;
    // STABLE entered 3 edges after the rise; the glitch is seen with cnt=5,
    // then the re-rise needs the full 2+1+8 again.
    push("stable_glitch_release", 7 + STB_C + 3);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (sys_reset == 1'b0) begin
        lat = i;
        break;
      end
      if (i == 6) pll_lock = 1'b0;
      if (i == 7) pll_lock = 1'b1;
    end
    chk(lat);

    // ---- test 5: relock counter saturation ----
    model = 2;
    tmo_seen = 0;
    sat_checked = 1'b0;
    for (int n = 0; n < 256; n++) begin
      pll_lock = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (sys_reset == 1'b1) begin
          lat = i;
          break;
        end
      end
      if (lat < 0) tmo_seen++;
      if (model < 255) model++;
      pll_lock = 1'b1;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (locked == 1'b1) begin
          lat = i;
          break;
        end
      end
      if (lat < 0) tmo_seen++;
      if (model == 255 && !sat_checked) begin
        sat_checked = 1'b1;
        push("relock_reach_255", model);
        chk({24'd0, relock_count});
      end
    end
    push("relock_saturated", model);
    chk({24'd0, relock_count});
    push("sat_loop_timeouts", 32'd0);
    chk(tmo_seen);

    // ---- test 6a: async reset while in RUN ----
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("reset_in_run");
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);

    // ---- test 2: no lock, periodic retries (or FAULT with retry limit) ----
    reset = 1'b0;
    prev = 1'b1;
    r1 = -1;
    r2 = -1;
    viol = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sys_reset !== 1'b1) viol++;
      if (pll_reset == 1'b1 && prev == 1'b0) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = pll_reset;
    end
    push("first_retry_at", RST_C + TMO_C);
    push("retry_period", RST_C + TMO_C);
    push("nolock_sys_reset_low", 32'd0);
    chk(r1);
    chk(r2 - r1);
    chk(viol);
`ifdef PLL_RETRY_LIMIT_EN
    push("fault_after_retries", 32'd1);
    push("fault_pll_reset", 32'd1);
`else
    push("no_fault", 32'd0);
    push("pll_reset_low_between", 32'd0);
`endif
    chk({31'd0, fault});
    chk({31'd0, pll_reset});

    // ---- test 6b: async reset while in FAULT / retrying ----
    #2 reset = 1'b1;
    #1 chk_reset_vals("reset_in_fault");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
